// File: rtl/rv_pkg.sv
// Shared RISC-V core constants and writeback request types.
package rv_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    // Successor of index k in a ring of n slots.
    function automatic int rr_next(input int k, input int n);
        return (k + 1 >= n) ? 0 : k + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requesting index at or after ptr wins.
module rr_arbiter
    import rv_pkg::*;
#(
    parameter int N     = 3,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic             hold,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    int cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        if (!hold) begin
            for (int off = 0; off < N; off++) begin
                cand = (int'(ptr) + off) % N;
                if (!any && req[cand]) begin
                    any         = 1'b1;
                    grant[cand] = 1'b1;
                    idx         = PTR_W'(cand);
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between N_REQ writeback requesters.
// Define REGFILE_WB_FWD_EN to add two write-to-read forwarding compare ports.
module regfile_wb_arbiter
    import rv_pkg::*;
#(
    parameter int N_REQ  = 3,
    parameter int DATA_W = XLEN,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic                    clk,
    input  logic                    srst,
    input  logic                    wb_hold,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic                    rf_write,
    output logic [ADDR_W-1:0]       rf_waddr,
    output logic [DATA_W-1:0]       rf_wdata,
`ifdef REGFILE_WB_FWD_EN
    input  logic [ADDR_W-1:0]       fwd_raddr1,
    input  logic [ADDR_W-1:0]       fwd_raddr2,
    output logic                    fwd_hit1,
    output logic                    fwd_hit2,
    output logic [DATA_W-1:0]       fwd_data1,
    output logic [DATA_W-1:0]       fwd_data2,
`endif
    output logic                    waw_conflict
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              rf_write_q, rf_write_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic              waw_q, waw_d;

    logic [N_REQ-1:0]  grant;
    logic [PTR_W-1:0]  grant_idx;
    logic              transfer;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // Reset doubles as a hold so nothing can transfer while the datapath is clearing.
    rr_arbiter #(
        .N     (N_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req   (req_valid),
        .hold  (wb_hold | srst),
        .ptr   (rr_ptr_q),
        .grant (grant),
        .idx   (grant_idx),
        .any   (transfer)
    );

    assign req_ready = grant;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        waw_d = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            for (int j = i + 1; j < N_REQ; j++) begin
                if (req_valid[i] && req_valid[j] &&
                    req_addr[i*ADDR_W +: ADDR_W] == req_addr[j*ADDR_W +: ADDR_W] &&
                    req_addr[i*ADDR_W +: ADDR_W] != ZERO_IDX) begin
                    waw_d = 1'b1;
                end
            end
        end
    end

    // x0 writes still consume a grant and advance the pointer but never reach the file.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        rf_write_d = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (transfer) begin
            rr_ptr_d   = PTR_W'(rr_next(int'(grant_idx), N_REQ));
            rf_write_d = (sel_addr != ZERO_IDX);
            rf_waddr_d = sel_addr;
            rf_wdata_d = sel_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            rr_ptr_q   <= '0;
            rf_write_q <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            waw_q      <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            rf_write_q <= rf_write_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            waw_q      <= waw_d;
        end
    end

    assign rf_write     = rf_write_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign waw_conflict = waw_q;

`ifdef REGFILE_WB_FWD_EN
    // Bypass the file's write-to-read gap for the write currently being presented.
    assign fwd_hit1  = rf_write_q && (fwd_raddr1 == rf_waddr_q) && (fwd_raddr1 != ZERO_IDX);
    assign fwd_hit2  = rf_write_q && (fwd_raddr2 == rf_waddr_q) && (fwd_raddr2 != ZERO_IDX);
    assign fwd_data1 = fwd_hit1 ? rf_wdata_q : '0;
    assign fwd_data2 = fwd_hit2 ? rf_wdata_q : '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (N_REQ=3, 32-bit data, 5-bit index).
module tb_regfile_wb_arbiter;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            srst;
    logic            wb_hold;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic            rf_write;
    logic [AW-1:0]   rf_waddr;
    logic [DW-1:0]   rf_wdata;
    logic            waw_conflict;
`ifdef REGFILE_WB_FWD_EN
    logic [AW-1:0]   fwd_raddr1 = '0;
    logic [AW-1:0]   fwd_raddr2 = '0;
    logic            fwd_hit1, fwd_hit2;
    logic [DW-1:0]   fwd_data1, fwd_data2;
`endif

    int numCompared = 0;
    int numMismatched = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk          (clk),
        .srst         (srst),
        .wb_hold      (wb_hold),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .rf_write     (rf_write),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
`ifdef REGFILE_WB_FWD_EN
        .fwd_raddr1   (fwd_raddr1),
        .fwd_raddr2   (fwd_raddr2),
        .fwd_hit1     (fwd_hit1),
        .fwd_hit2     (fwd_hit2),
        .fwd_data1    (fwd_data1),
        .fwd_data2    (fwd_data2),
`endif
        .waw_conflict (waw_conflict)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        numCompared++;
        if (observed !== expected) begin
            numMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic setReq(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    // Drives control inputs, then lets combinational outputs settle before checks.
    task automatic applyStimulus(input logic rst, input logic hold, input logic [N-1:0] valid);
        srst      = rst;
        wb_hold   = hold;
        req_valid = valid;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        req_addr = '0;
        req_data = '0;
        setReq(0, 5'd1, 32'hA000_0000);
        setReq(1, 5'd2, 32'hA000_0001);
        setReq(2, 5'd3, 32'hA000_0002);

        // Reset held for two edges with every requester valid.
        applyStimulus(1'b1, 1'b0, 3'b111);
        checkOutput("rst_ready0", 64'(req_ready), 64'h0);
        step();
        checkOutput("rst_ready1", 64'(req_ready), 64'h0);
        checkOutput("rst_write1", 64'(rf_write), 64'h0);
        step();
        checkOutput("rst_write2", 64'(rf_write), 64'h0);
        checkOutput("rst_waddr", 64'(rf_waddr), 64'h0);
        checkOutput("rst_wdata", 64'(rf_wdata), 64'h0);
        checkOutput("rst_waw", 64'(waw_conflict), 64'h0);

        // Fairness: all valid from rr_ptr=0 gives grants 0,1,2,0,1,2.
        applyStimulus(1'b0, 1'b0, 3'b111);
        for (int c = 0; c < 6; c++) begin
            checkOutput($sformatf("fair_ready%0d", c), 64'(req_ready), 64'(3'b001 << (c % 3)));
            step();
            checkOutput($sformatf("fair_write%0d", c), 64'(rf_write), 64'h1);
            checkOutput($sformatf("fair_waddr%0d", c), 64'(rf_waddr), 64'((c % 3) + 1));
            checkOutput($sformatf("fair_wdata%0d", c), 64'(rf_wdata), 64'(32'hA000_0000 + (c % 3)));
        end

        // Single requester 1 from rr_ptr=0.
        setReq(1, 5'd7, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 1'b0, 3'b010);
        checkOutput("single_ready", 64'(req_ready), 64'(3'b010));
        step();
        checkOutput("single_write", 64'(rf_write), 64'h1);
        checkOutput("single_waddr", 64'(rf_waddr), 64'd7);
        checkOutput("single_wdata", 64'(rf_wdata), 64'hDEAD_BEEF);
        applyStimulus(1'b0, 1'b0, 3'b111);
        checkOutput("single_ptr2", 64'(req_ready), 64'(3'b100));

        // x0 write: granted (ptr -> 1) but not written.
        setReq(0, 5'd0, 32'h1234_5678);
        applyStimulus(1'b0, 1'b0, 3'b001);
        checkOutput("x0_ready", 64'(req_ready), 64'(3'b001));
        step();
        checkOutput("x0_write", 64'(rf_write), 64'h0);

        // Hold for three cycles with requester 2 valid.
        setReq(2, 5'd12, 32'h0000_00C2);
        applyStimulus(1'b0, 1'b1, 3'b100);
        for (int c = 0; c < 3; c++) begin
            checkOutput($sformatf("hold_ready%0d", c), 64'(req_ready), 64'h0);
            step();
            checkOutput($sformatf("hold_write%0d", c), 64'(rf_write), 64'h0);
        end
        applyStimulus(1'b0, 1'b0, 3'b100);
        checkOutput("unhold_ready", 64'(req_ready), 64'(3'b100));
        step();
        checkOutput("unhold_write", 64'(rf_write), 64'h1);
        checkOutput("unhold_waddr", 64'(rf_waddr), 64'd12);
        checkOutput("unhold_wdata", 64'(rf_wdata), 64'hC2);

        // Registered write survives a hold; pointer (now 2) is frozen across it.
        setReq(1, 5'd3, 32'h0000_0D0D);
        applyStimulus(1'b0, 1'b0, 3'b010);
        checkOutput("hp_ready", 64'(req_ready), 64'(3'b010));
        step();
        applyStimulus(1'b0, 1'b1, 3'b010);
        checkOutput("hp_ready_held", 64'(req_ready), 64'h0);
        checkOutput("hp_write", 64'(rf_write), 64'h1);
        checkOutput("hp_waddr", 64'(rf_waddr), 64'd3);
        step();
        checkOutput("hp_write_after", 64'(rf_write), 64'h0);
        setReq(0, 5'd6, 32'h0000_0006);
        applyStimulus(1'b0, 1'b0, 3'b011);
        checkOutput("hp_ptr_frozen", 64'(req_ready), 64'(3'b001));
        step();
        checkOutput("hp_waddr6", 64'(rf_waddr), 64'd6);

        // WAW on index 5 between requesters 0 and 2 (ptr=1, so 2 wins).
        setReq(0, 5'd5, 32'h0000_0050);
        setReq(2, 5'd5, 32'h0000_0052);
        applyStimulus(1'b0, 1'b0, 3'b101);
        checkOutput("waw_ready", 64'(req_ready), 64'(3'b100));
        step();
        checkOutput("waw_set", 64'(waw_conflict), 64'h1);
        checkOutput("waw_wdata", 64'(rf_wdata), 64'h52);
        setReq(0, 5'd0, 32'h0);
        setReq(2, 5'd0, 32'h0);
        applyStimulus(1'b0, 1'b0, 3'b101);
        step();
        checkOutput("waw_x0", 64'(waw_conflict), 64'h0);
        setReq(0, 5'd9, 32'h0);
        setReq(1, 5'd9, 32'h0);
        applyStimulus(1'b0, 1'b1, 3'b011);
        step();
        checkOutput("waw_hold", 64'(waw_conflict), 64'h1);

`ifdef REGFILE_WB_FWD_EN
        setReq(0, 5'd9, 32'h0000_0055);
        fwd_raddr1 = 5'd9;
        fwd_raddr2 = 5'd0;
        applyStimulus(1'b0, 1'b0, 3'b001);
        step();
        checkOutput("fwd_hit1", 64'(fwd_hit1), 64'h1);
        checkOutput("fwd_data1", 64'(fwd_data1), 64'h55);
        checkOutput("fwd_hit2", 64'(fwd_hit2), 64'h0);
        checkOutput("fwd_data2", 64'(fwd_data2), 64'h0);
`endif

        // Reset while a write is being presented discards it.
        setReq(1, 5'd4, 32'h0000_0044);
        applyStimulus(1'b0, 1'b0, 3'b010);
        step();
        checkOutput("mid_write_pre", 64'(rf_write), 64'h1);
        applyStimulus(1'b1, 1'b0, 3'b010);
        checkOutput("mid_ready", 64'(req_ready), 64'h0);
        step();
        checkOutput("mid_write", 64'(rf_write), 64'h0);
        applyStimulus(1'b0, 1'b0, 3'b111);
        checkOutput("mid_first_grant", 64'(req_ready), 64'(3'b001));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (write/waddr/wdata) between N_REQ writeback requesters (ALU, load unit, mul/div).
- Round-robin arbitration with valid/ready handshakes; one registered write per cycle to the register file.
- Drops writes to x0, supports a pipeline hold, and flags same-cycle WAW collisions.

Parameters:
- N_REQ, 3, number of writeback requesters (2..8)
- DATA_W, 32, register data width
- ADDR_W, 5, register index width

Ports:
- clk  input  1  clock, rising edge
- srst  input  1  synchronous active-high reset
- wb_hold  input  1  when 1, no grants are issued this cycle
- req_valid  input  N_REQ  per-requester write request
- req_ready  output  N_REQ  per-requester grant (combinational)
- req_addr  input  N_REQ*ADDR_W  packed destination indices; requester i at [i*ADDR_W +: ADDR_W]
- req_data  input  N_REQ*DATA_W  packed write data; requester i at [i*DATA_W +: DATA_W]
- rf_write  output  1  register file write enable (registered)
- rf_waddr  output  ADDR_W  register file write index (registered)
- rf_wdata  output  DATA_W  register file write data (registered)
- waw_conflict  output  1  registered pulse: two or more valid requests targeted the same nonzero index last cycle

Behaviour:
- Reset (srst=1 at an edge): rf_write=0, rf_waddr=0, rf_wdata=0, waw_conflict=0, rr_ptr=0.
- While srst=1, req_ready=0 combinationally, so no transfers occur.
- Transfer: requester i transfers in cycle t when req_valid[i] & req_ready[i].
  - Requesters must hold valid, addr and data stable until the transfer.
  - valid must not drop before the transfer.
- At most one req_ready bit is high per cycle. None is high when wb_hold=1 or no request is valid.
- Arbitration (rr_ptr, width clog2(N_REQ)):
  - Search indices rr_ptr, rr_ptr+1, … modulo N_REQ.
  - The first valid index k wins: req_ready[k]=1.
  - On a transfer, rr_ptr <= (k+1) mod N_REQ. With no transfer, rr_ptr is unchanged.
- Latency: a transfer in cycle t gives rf_write=1, rf_waddr=addr, rf_wdata=data in cycle t+1. The register file commits the value on the following edge.
- Cycles with no transfer: rf_write=0 next cycle. rf_waddr/rf_wdata hold their previous values.
- x0: a request with addr=0 still gets a grant, transfers and advances rr_ptr, but rf_write=0 next cycle.
- wb_hold:
  - Blocks grants only. rr_ptr is frozen.
  - A write already registered is still presented in the following cycle.
- waw_conflict: registered from the current cycle's requests; set if two or more req_valid bits with equal nonzero addresses are present. Independent of hold and grant.
- Reset mid-operation: a pending registered write is discarded (rf_write=0). Requesters must re-present.
- N_REQ=1: rr_ptr is constant 0 and the grant is simply valid & ~wb_hold.

Optional Feature:
- Macro: REGFILE_WB_FWD_EN.
- With the macro, add these ports:
  - fwd_raddr1  input  ADDR_W
  - fwd_raddr2  input  ADDR_W
  - fwd_hit1  output  1
  - fwd_hit2  output  1
  - fwd_data1  output  DATA_W
  - fwd_data2  output  DATA_W
- fwd_hitN = rf_write & (fwd_raddrN == rf_waddr) & (fwd_raddrN != 0), combinational.
- fwd_dataN = rf_wdata when hit, else 0.
- This lets read stages bypass the register file's one-cycle write-to-read gap.
- Without the macro these ports do not exist and there is no compare logic.

Decomposition:
- Shared package rv_pkg holds:
  - constants REG_ADDR_W=5, XLEN=32, REG_ZERO=5'd0
  - typedef wb_req_t {addr, data}
- One natural sub-module, rr_arbiter: inputs req, hold, ptr; outputs one-hot grant and encoded index. It is reused by future memory-port sharing.

Test Plan:
- Reset: srst=1 for 2 cycles with all req_valid=1 -> req_ready=0, rf_write=0. After release, the first grant goes to index 0.
- Single requester: req1 valid, addr=7, data=0xDEADBEEF in cycle t -> req_ready=3'b010 at t; rf_write=1, rf_waddr=7, rf_wdata=0xDEADBEEF at t+1; rr_ptr=2.
- Fairness: all three valid continuously for 6 cycles from rr_ptr=0 -> grant order 0,1,2,0,1,2; rf_write=1 on each following cycle.
- x0 drop plus hold:
  - req0 addr=0 -> granted, but rf_write=0 next cycle.
  - wb_hold=1 for 3 cycles with req2 valid -> req_ready=0 throughout.
  - Hold drops -> req2 granted immediately; rr_ptr unchanged during hold.
- WAW: req0 and req2 both valid with addr=5 -> waw_conflict=1 the next cycle. Same test with addr=0 -> waw_conflict=0.
- With REGFILE_WB_FWD_EN: write addr=9, data=0x55 pending while fwd_raddr1=9, fwd_raddr2=0 -> fwd_hit1=1, fwd_data1=0x55, fwd_hit2=0.
